// File: rtl/mcu_sequencer.sv
// rtl/mcu_sequencer.sv - program sequencer feeding an mcu datapath from internal instruction RAM
module mcu_sequencer #(
  parameter int op_sz   = 32,
  parameter int mem_sz  = 10,
  parameter int prog_sz = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_we,
  input  logic [prog_sz-1:0]            prog_addr,
  input  logic [4+2*mem_sz+op_sz-1:0]   prog_data,
  input  logic                          start,
  input  logic                          stop_on_err,
  output logic                          busy,
  output logic                          done,
  output logic                          abort,
  output logic [op_sz-1:0]              last_out,
  output logic [prog_sz:0]              instr_count,
  output logic [prog_sz:0]              err_count,
  output logic                          mcu_reset,
  output logic [3:0]                    mcu_op,
  output logic [mem_sz-1:0]             mcu_op0,
  output logic [op_sz-1:0]              mcu_op1,
  output logic [mem_sz-1:0]             mcu_op2,
  input  logic [op_sz-1:0]              mcu_out,
  input  logic                          mcu_op_err
);

  localparam int iw = 4 + 2*mem_sz + op_sz;
  localparam logic [prog_sz:0]   cnt_one = 1;
  localparam logic [prog_sz-1:0] pc_one  = 1;
  localparam logic [3:0]         op_read = 4'd7;
  localparam logic [3:0]         op_halt = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [iw-1:0]      ram [0:(1<<prog_sz)-1];
  logic [iw-1:0]      fetch_word;
  logic               fetch_halt;
  logic [iw-1:0]      ir;
  logic [prog_sz-1:0] pc;
  logic               soe;

  assign mcu_reset  = reset;
  assign fetch_word = ram[pc];
  assign fetch_halt = (fetch_word[iw-1 -: 4] == op_halt);

  // Program RAM: loader writes only while idle; contents survive reset
  always_ff @(posedge clk) begin
    if (prog_we && state == S_IDLE) begin
      ram[prog_addr] <= prog_data;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: one instruction takes FETCH/ISSUE/CAPTURE; HALT, error abort or last slot end the run
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_FETCH;
      S_FETCH:   state_next = fetch_halt ? S_DONE : S_ISSUE;
      S_ISSUE:   state_next = S_CAPTURE;
      S_CAPTURE: begin
        if (mcu_op_err && soe) begin
          state_next = S_DONE;
        end else if (&pc) begin
          state_next = S_DONE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs: operands reach the mcu only in ISSUE; otherwise a harmless READ of address 0
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    mcu_op  = op_read;
    mcu_op0 = '0;
    mcu_op1 = '0;
    mcu_op2 = '0;
    case (state)
      S_FETCH:   busy = 1'b1;
      S_ISSUE: begin
        busy    = 1'b1;
        mcu_op  = ir[iw-1 -: 4];
        mcu_op0 = ir[iw-5 -: mem_sz];
        mcu_op2 = ir[op_sz+mem_sz-1 -: mem_sz];
        mcu_op1 = ir[op_sz-1:0];
      end
      S_CAPTURE: busy = 1'b1;
      S_DONE:    done = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  // Datapath: pc, instruction register, result capture and run statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      ir          <= '0;
      soe         <= 1'b0;
      abort       <= 1'b0;
      last_out    <= '0;
      instr_count <= '0;
      err_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc          <= '0;
            soe         <= stop_on_err;
            abort       <= 1'b0;
            last_out    <= '0;
            instr_count <= '0;
            err_count   <= '0;
          end
        end
        S_FETCH: ir <= fetch_word;
        S_ISSUE: instr_count <= instr_count + cnt_one;
        S_CAPTURE: begin
          last_out <= mcu_out;
          if (mcu_op_err) begin
            err_count <= err_count + cnt_one;
          end
          if (mcu_op_err && soe) begin
            abort <= 1'b1;
          end else if (!(&pc)) begin
            pc <= pc + pc_one;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_sequencer.sv
// tb/tb_mcu_sequencer.sv - self-checking bench for mcu_sequencer with a behavioural mcu
module tb_mcu_sequencer;
  localparam int op_sz   = 32;
  localparam int mem_sz  = 10;
  localparam int prog_sz = 6;
  localparam int iw      = 4 + 2*mem_sz + op_sz;
  localparam int psz     = 1 << prog_sz;

  logic clk = 1'b0;
  logic reset, prog_we, start, stop_on_err;
  logic [prog_sz-1:0] prog_addr;
  logic [iw-1:0] prog_data;
  logic busy, done, abort;
  logic [op_sz-1:0] last_out;
  logic [prog_sz:0] instr_count, err_count;
  logic mcu_reset;
  logic [3:0] mcu_op;
  logic [mem_sz-1:0] mcu_op0, mcu_op2;
  logic [op_sz-1:0] mcu_op1, mcu_out;
  logic mcu_op_err;

  always #5 clk = ~clk;

  mcu_sequencer #(.op_sz(op_sz), .mem_sz(mem_sz), .prog_sz(prog_sz)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .stop_on_err(stop_on_err), .busy(busy), .done(done), .abort(abort),
    .last_out(last_out), .instr_count(instr_count), .err_count(err_count), .mcu_reset(mcu_reset),
    .mcu_op(mcu_op), .mcu_op0(mcu_op0), .mcu_op1(mcu_op1), .mcu_op2(mcu_op2),
    .mcu_out(mcu_out), .mcu_op_err(mcu_op_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // mcu semantics: returns {op_err, out}
  function automatic logic [32:0] mcu_eval(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] w);
    case (op)
      4'd0: return {1'b0, a + b};
      4'd1: return {1'b0, a - b};
      4'd2: return {1'b0, a * b};
      4'd3: return (b == 0) ? {1'b1, 32'd0} : {1'b0, a / b};
      4'd4: return {1'b0, a & b};
      4'd5: return {1'b0, a | b};
      4'd6: return {1'b0, a ^ b};
      4'd7: return {1'b0, a};
      4'd8: return {1'b0, w};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic logic [iw-1:0] mk(input logic [3:0] op, input logic [9:0] o0,
                                       input logic [31:0] o1, input logic [9:0] o2);
    return {op, o0, o2, o1};
  endfunction

  // Behavioural mcu: result registered at the edge ending ISSUE
  logic [31:0] mcu_mem [0:1023];
  logic [32:0] mr;
  always @(posedge clk) begin
    if (mcu_reset) begin
      mcu_out    <= '0;
      mcu_op_err <= 1'b0;
    end else begin
      mr = mcu_eval(mcu_op, mcu_mem[mcu_op0], mcu_mem[mcu_op1[9:0]], mcu_op1);
      mcu_out    <= mr[31:0];
      mcu_op_err <= mr[32];
      if (!mr[32] && mcu_op <= 4'd6) mcu_mem[mcu_op2] <= mr[31:0];
      if (mcu_op == 4'd8) mcu_mem[mcu_op0] <= mcu_op1;
    end
  end

  typedef struct {
    bit busy, done, abort, logit;
    logic [3:0] op;
    logic [9:0] op0, op2;
    logic [31:0] op1, lo;
    int ic, ec;
  } ent_t;

  ent_t exp_q[$];
  logic [iw-1:0] prog [0:psz-1];
  logic [iw-1:0] pq[$];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] dut_log[$];
  int negs = 0, done_neg = 0, start_neg = 0;
  bit idle_chk = 0;

  function automatic void push(input bit b, input bit d, input bit ab, input logic [3:0] op,
                               input logic [9:0] o0, input logic [31:0] o1, input logic [9:0] o2,
                               input logic [31:0] lo, input int ic, input int ec, input bit lg);
    ent_t e;
    e.busy = b; e.done = d; e.abort = ab; e.op = op; e.op0 = o0; e.op1 = o1; e.op2 = o2;
    e.lo = lo; e.ic = ic; e.ec = ec; e.logit = lg;
    exp_q.push_back(e);
  endfunction

  // Expected cycle-by-cycle trace of one run, from the program and the mcu semantics
  task automatic build(input bit soe);
    int pc = 0, ic = 0, ec = 0;
    logic [31:0] lo = 0;
    bit ab = 0, lg = 0;
    logic [iw-1:0] w;
    logic [3:0] op;
    logic [9:0] a0, a2;
    logic [31:0] a1;
    logic [32:0] r;
    forever begin
      w = prog[pc];
      op = w[iw-1 -: 4]; a0 = w[iw-5 -: 10]; a2 = w[41:32]; a1 = w[31:0];
      push(1, 0, 0, 4'd7, 0, 0, 0, lo, ic, ec, lg);
      lg = 0;
      if (op == 4'hF) break;
      push(1, 0, 0, op, a0, a1, a2, lo, ic, ec, 0);
      ic++;
      push(1, 0, 0, 4'd7, 0, 0, 0, lo, ic, ec, 0);
      r = mcu_eval(op, ref_mem[a0], ref_mem[a1[9:0]], a1);
      if (!r[32] && op <= 4'd6) ref_mem[a2] = r[31:0];
      if (op == 4'd8) ref_mem[a0] = a1;
      lo = r[31:0];
      lg = 1;
      if (r[32]) ec++;
      if (r[32] && soe) begin ab = 1; break; end
      if (pc == psz-1) break;
      pc++;
    end
    push(0, 1, ab, 4'd7, 0, 0, 0, lo, ic, ec, lg);
  endtask

  // Single compare process against the expected trace
  ent_t ce;
  always @(negedge clk) begin
    negs++;
    chk("mcu_reset", {63'd0, mcu_reset}, {63'd0, reset});
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("busy", {63'd0, busy}, {63'd0, ce.busy});
      chk("done", {63'd0, done}, {63'd0, ce.done});
      chk("mcu_op", {60'd0, mcu_op}, {60'd0, ce.op});
      chk("mcu_op0", {54'd0, mcu_op0}, {54'd0, ce.op0});
      chk("mcu_op1", {32'd0, mcu_op1}, {32'd0, ce.op1});
      chk("mcu_op2", {54'd0, mcu_op2}, {54'd0, ce.op2});
      chk("last_out", {32'd0, last_out}, {32'd0, ce.lo});
      chk("instr_count", {57'd0, instr_count}, 64'(ce.ic));
      chk("err_count", {57'd0, err_count}, 64'(ce.ec));
      if (ce.done) begin
        chk("abort", {63'd0, abort}, {63'd0, ce.abort});
        done_neg = negs;
      end
      if (ce.logit) dut_log.push_back(last_out);
    end else if (idle_chk) begin
      chk("idle_busy", {63'd0, busy}, 64'd0);
      chk("idle_done", {63'd0, done}, 64'd0);
      chk("idle_mcu_op", {60'd0, mcu_op}, 64'd7);
    end
  end

  task automatic load();
    foreach (pq[i]) begin
      @(posedge clk); #1;
      prog_we = 1'b1; prog_addr = prog_sz'(i); prog_data = pq[i]; prog[i] = pq[i];
    end
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic start_run(input bit soe, input bit wr0, input logic [iw-1:0] w0);
    @(posedge clk); #1;
    start = 1'b1; stop_on_err = soe;
    if (wr0) begin prog_we = 1'b1; prog_addr = '0; prog_data = w0; prog[0] = w0; end
    @(posedge clk);
    build(soe);
    start_neg = negs;
    #1;
    start = 1'b0; prog_we = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    while (exp_q.size() > 0 && g < 1000) begin @(negedge clk); g++; end
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin mcu_mem[i] = '0; ref_mem[i] = '0; end
    reset = 1'b1; prog_we = 1'b0; start = 1'b0; stop_on_err = 1'b0;
    prog_addr = '0; prog_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_abort", {63'd0, abort}, 64'd0);
    chk("rst_last_out", {32'd0, last_out}, 64'd0);
    chk("rst_instr_count", {57'd0, instr_count}, 64'd0);
    chk("rst_err_count", {57'd0, err_count}, 64'd0);
    chk("rst_mcu_op", {60'd0, mcu_op}, 64'd7);
    chk("rst_mcu_ops", {mcu_op0, mcu_op2, mcu_op1[11:0], 32'd0}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_chk = 1;

    // WRITE, WRITE, ADD, HALT
    pq.delete();
    pq.push_back(mk(8, 100, 2, 0)); pq.push_back(mk(8, 101, 1, 0));
    pq.push_back(mk(0, 100, 101, 102)); pq.push_back(mk(15, 0, 0, 0));
    load();
    start_run(0, 0, '0);
    wait_done("t1_timeout");
    chk("t1_last_out", {32'd0, last_out}, 64'd3);
    chk("t1_instr_count", {57'd0, instr_count}, 64'd3);
    chk("t1_err_count", {57'd0, err_count}, 64'd0);
    chk("t1_abort", {63'd0, abort}, 64'd0);
    chk("t1_done_latency", 64'(done_neg - start_neg), 64'd11);

    // SUB..XOR each followed by READ(102)
    pq.delete();
    pq.push_back(mk(8, 100, 2, 0)); pq.push_back(mk(8, 101, 1, 0));
    for (int op = 1; op <= 6; op++) begin
      pq.push_back(mk(4'(op), 100, 101, 102));
      pq.push_back(mk(7, 102, 0, 0));
    end
    pq.push_back(mk(15, 0, 0, 0));
    load();
    dut_log.delete();
    start_run(0, 0, '0);
    wait_done("t2_timeout");
    chk("t2_log_size", 64'(dut_log.size()), 64'd14);
    if (dut_log.size() == 14) begin
      chk("t2_read_sub", {32'd0, dut_log[3]}, 64'd1);
      chk("t2_read_mul", {32'd0, dut_log[5]}, 64'd2);
      chk("t2_read_div", {32'd0, dut_log[7]}, 64'd2);
      chk("t2_read_and", {32'd0, dut_log[9]}, 64'd0);
      chk("t2_read_or", {32'd0, dut_log[11]}, 64'd3);
      chk("t2_read_xor", {32'd0, dut_log[13]}, 64'd3);
    end

    // Top-of-memory operands
    pq.delete();
    pq.push_back(mk(8, 1000, 6, 0)); pq.push_back(mk(8, 1001, 3, 0));
    for (int op = 0; op <= 3; op++) pq.push_back(mk(4'(op), 1000, 1001, 1002));
    pq.push_back(mk(15, 0, 0, 0));
    load();
    dut_log.delete();
    start_run(0, 0, '0);
    wait_done("t3_timeout");
    chk("t3_log_size", 64'(dut_log.size()), 64'd6);
    if (dut_log.size() == 6) begin
      chk("t3_add", {32'd0, dut_log[2]}, 64'd9);
      chk("t3_sub", {32'd0, dut_log[3]}, 64'd3);
      chk("t3_mul", {32'd0, dut_log[4]}, 64'd18);
      chk("t3_div", {32'd0, dut_log[5]}, 64'd2);
    end

    // Invalid opcode written to slot 0 in the same cycle as start
    pq.delete();
    pq.push_back(mk(7, 0, 0, 0)); pq.push_back(mk(0, 100, 101, 102)); pq.push_back(mk(15, 0, 0, 0));
    load();
    start_run(0, 1, mk(10, 0, 0, 0));
    wait_done("t4a_timeout");
    chk("t4a_instr_count", {57'd0, instr_count}, 64'd2);
    chk("t4a_err_count", {57'd0, err_count}, 64'd1);
    chk("t4a_abort", {63'd0, abort}, 64'd0);
    start_run(1, 0, '0);
    wait_done("t4b_timeout");
    chk("t4b_instr_count", {57'd0, instr_count}, 64'd1);
    chk("t4b_err_count", {57'd0, err_count}, 64'd1);
    chk("t4b_abort", {63'd0, abort}, 64'd1);

    // Full program of ADDs, with ignored start/prog_we pulses mid-run
    pq.delete();
    for (int i = 0; i < psz; i++) pq.push_back(mk(0, 100, 101, 102));
    load();
    start_run(0, 0, '0);
    repeat (4) @(posedge clk);
    #1; prog_we = 1'b1; prog_addr = 6'd5; prog_data = mk(15, 0, 0, 0);
    @(posedge clk); #1; prog_we = 1'b0;
    repeat (10) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done("t5_timeout");
    chk("t5_instr_count", {57'd0, instr_count}, 64'd64);
    chk("t5_abort", {63'd0, abort}, 64'd0);
    chk("t5_done_latency", 64'(done_neg - start_neg), 64'd193);
    start_run(0, 0, '0);
    wait_done("t5b_timeout");
    chk("t5b_instr_count", {57'd0, instr_count}, 64'd64);

    // Reset during ISSUE of the third instruction
    pq.delete();
    pq.push_back(mk(8, 100, 2, 0)); pq.push_back(mk(8, 101, 1, 0));
    pq.push_back(mk(0, 100, 101, 102)); pq.push_back(mk(15, 0, 0, 0));
    load();
    start_run(0, 0, '0);
    repeat (7) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1; reset = 1'b0;
    @(negedge clk);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_mcu_op", {60'd0, mcu_op}, 64'd7);
    chk("t6_instr_count", {57'd0, instr_count}, 64'd0);
    chk("t6_err_count", {57'd0, err_count}, 64'd0);
    repeat (12) @(negedge clk);
    start_run(0, 0, '0);
    wait_done("t6_timeout");
    chk("t6_restart_instr_count", {57'd0, instr_count}, 64'd3);
    chk("t6_restart_last_out", {32'd0, last_out}, 64'd3);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
